// File: rtl/hwpe_stream_sink_realign_offset_if.sv
// Valid/ready byte-strobed stream bundle shared by the realigner's input and output.
// The sink side consumes data; the source side produces it.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport sink (input valid, input data, input strb, output ready);
  modport source (output valid, output data, output strb, input ready);
endinterface

// File: rtl/hwpe_stream_sink_realign_offset.sv
// Shifts a word-aligned stream up by a byte offset. Bytes pushed past the top of a word
// are carried into the next beat, and one trailing beat drains the last carry.
module hwpe_stream_sink_realign_offset #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 test_mode_i,
  input  logic                                 start_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]      offset_i,
  input  logic [15:0]                          len_i,
  hwpe_stream_intf_stream.sink                 push_i,
  hwpe_stream_intf_stream.source               pop_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned SW = $clog2(DATA_WIDTH) + 1;
  localparam logic [SW-1:0] DW_SH = SW'(DATA_WIDTH);
  localparam logic [OW:0]   NB_SH = (OW+1)'(NB);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [OW-1:0]         off_r, off_nxt_s;
  logic [15:0]           len_r, len_nxt_s;
  logic [15:0]           cnt_r, cnt_nxt_s;
  logic [DATA_WIDTH-1:0] carry_r, carry_nxt_s;
  logic [NB-1:0]         carry_strb_r, carry_strb_nxt_s;
  logic                  done_r, done_nxt_s;

  logic [SW-1:0]         lsh_s;
  logic [DATA_WIDTH-1:0] shl_data_s, shr_data_s;
  logic [NB-1:0]         shl_strb_s, shr_strb_s;
  logic                  hs_s, last_s;
  logic                  push_ready_s, pop_valid_s;
  logic [DATA_WIDTH-1:0] pop_data_s;
  logic [NB-1:0]         pop_strb_s;
  logic                  unused_s;

  assign unused_s = test_mode_i;
  assign lsh_s    = SW'({off_r, 3'b000});
  assign hs_s     = push_i.valid & pop_o.ready;
  assign last_s   = (cnt_r == (len_r - 16'd1));

  // Low part lands in the current beat, high part is kept as carry for the next one.
  always_comb begin
    shl_data_s = push_i.data << lsh_s;
    shl_strb_s = push_i.strb << off_r;
    if (off_r == '0) begin
      shr_data_s = '0;
      shr_strb_s = '0;
    end else begin
      shr_data_s = push_i.data >> (DW_SH - lsh_s);
      shr_strb_s = push_i.strb >> (NB_SH - {1'b0, off_r});
    end
  end

  // Next-state and stream handshake logic; clear_i overrides everything.
  always_comb begin
    state_nxt_s      = state_r;
    off_nxt_s        = off_r;
    len_nxt_s        = len_r;
    cnt_nxt_s        = cnt_r;
    carry_nxt_s      = carry_r;
    carry_strb_nxt_s = carry_strb_r;
    done_nxt_s       = 1'b0;
    push_ready_s     = 1'b0;
    pop_valid_s      = 1'b0;
    pop_data_s       = '0;
    pop_strb_s       = '0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          off_nxt_s        = offset_i;
          len_nxt_s        = len_i;
          cnt_nxt_s        = 16'd0;
          carry_nxt_s      = '0;
          carry_strb_nxt_s = '0;
          if (len_i == 16'd0) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = STREAM;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        pop_valid_s  = push_i.valid;
        push_ready_s = pop_o.ready;
        pop_data_s   = shl_data_s | carry_r;
        pop_strb_s   = shl_strb_s | carry_strb_r;
        if (hs_s) begin
          carry_nxt_s      = shr_data_s;
          carry_strb_nxt_s = shr_strb_s;
          cnt_nxt_s        = cnt_r + 16'd1;
          if (last_s) begin
            if (off_r == '0) begin
              done_nxt_s  = 1'b1;
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = FLUSH;
            end
          end else begin
            state_nxt_s = STREAM;
          end
        end else begin
          state_nxt_s = STREAM;
        end
      end
      FLUSH: begin
        pop_valid_s = 1'b1;
        pop_data_s  = carry_r;
        pop_strb_s  = carry_strb_r;
        if (pop_o.ready) begin
          done_nxt_s       = 1'b1;
          state_nxt_s      = IDLE;
          carry_nxt_s      = '0;
          carry_strb_nxt_s = '0;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (clear_i) begin
      state_nxt_s      = IDLE;
      cnt_nxt_s        = 16'd0;
      carry_nxt_s      = '0;
      carry_strb_nxt_s = '0;
      done_nxt_s       = 1'b0;
    end else begin
      done_nxt_s = done_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transfer context, carry and completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_r        <= '0;
      len_r        <= 16'd0;
      cnt_r        <= 16'd0;
      carry_r      <= '0;
      carry_strb_r <= '0;
      done_r       <= 1'b0;
    end else begin
      off_r        <= off_nxt_s;
      len_r        <= len_nxt_s;
      cnt_r        <= cnt_nxt_s;
      carry_r      <= carry_nxt_s;
      carry_strb_r <= carry_strb_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  assign push_i.ready = push_ready_s;
  assign pop_o.valid  = pop_valid_s;
  assign pop_o.data   = pop_data_s;
  assign pop_o.strb   = pop_strb_s;
  assign busy_o       = (state_r != IDLE);
  assign done_o       = done_r;

endmodule

// File: tb/tb_hwpe_stream_sink_realign_offset.sv
// Randomised bench for the byte-offset realigner: a byte-position model predicts every
// output beat, the done pulse and busy, and a few literal beats pin that model.
module tb_hwpe_stream_sink_realign_offset;

  localparam int DW = 32;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, test_mode, start;
  logic [1:0]  offset;
  logic [15:0] len;
  logic        busy, done;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop ();

  hwpe_stream_sink_realign_offset #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .test_mode_i(test_mode),
    .start_i(start), .offset_i(offset), .len_i(len),
    .push_i(push), .pop_o(pop), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  beat_t       drv_q[$], exp_q[$], cap_q[$];
  logic [31:0] tx_w[$];
  logic [3:0]  tx_s[$];
  int n_checks = 0, n_fail = 0;
  int push_stall = 0, pop_stall = 0;
  bit force_low = 1'b0;
  bit m_active = 1'b0, m_done = 1'b0, m_finished = 1'b0;
  bit prev_stall = 1'b0, prev_clear = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  // Output stream is input bytes placed at positions off, off+1, ...; empty lanes are 0.
  function automatic void build_exp(input int off, input int ln);
    logic [31:0] od [64];
    logic [3:0]  os [64];
    logic [31:0] w, t;
    logic [3:0]  s, ts;
    int nbeats, pos;
    nbeats = (off + 4*ln + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      od[b] = 32'd0;
      os[b] = 4'd0;
    end
    for (int i = 0; i < 4*ln; i++) begin
      pos = off + i;
      w = tx_w[i/4];
      s = tx_s[i/4];
      t = od[pos/4];
      ts = os[pos/4];
      t[8*(pos%4) +: 8] = w[8*(i%4) +: 8];
      ts[pos%4] = s[i%4];
      od[pos/4] = t;
      os[pos/4] = ts;
    end
    for (int b = 0; b < nbeats; b++) exp_q.push_back({od[b], os[b]});
  endfunction

  // Stream driver: holds a presented word until it is taken, random stalls on both sides.
  initial begin : drv
    bit hs;
    push.valid = 1'b0;
    push.data  = 32'd0;
    push.strb  = 4'd0;
    pop.ready  = 1'b0;
    forever begin
      @(negedge clk);
      hs = push.valid && push.ready;
      @(posedge clk);
      #1;
      if (hs) void'(drv_q.pop_front());
      if (hs || !push.valid) begin
        if (drv_q.size() > 0 && $urandom_range(99) >= push_stall) begin
          push.valid = 1'b1;
          push.data  = drv_q[0].d;
          push.strb  = drv_q[0].s;
        end else begin
          push.valid = 1'b0;
          push.data  = $urandom;
          push.strb  = 4'($urandom);
        end
      end
      pop.ready = !force_low && ($urandom_range(99) >= pop_stall);
    end
  end

  // Compare process: checks busy, done, idle outputs, stall stability and each output beat.
  always @(negedge clk) begin : cmp
    bit was_active;
    beat_t b;
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      if (m_done) m_finished = 1'b1;
      m_done = 1'b0;
      if (!m_active) begin
        chk("pop_valid_idle", 32'(pop.valid), 32'd0);
        chk("push_ready_idle", 32'(push.ready), 32'd0);
      end
      if (prev_stall && !prev_clear) begin
        chk("stall_valid", 32'(pop.valid), 32'd1);
        chk("stall_data", pop.data, prev_d);
        chk("stall_strb", 32'(pop.strb), 32'(prev_s));
      end
      was_active = m_active;
      if (pop.valid && pop.ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: actual %h/%h, required no beat", pop.data, pop.strb);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", pop.data, b.d);
          chk("beat_strb", 32'(pop.strb), 32'(b.s));
          cap_q.push_back({pop.data, pop.strb});
          if (exp_q.size() == 0) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end
      end
      if (clear) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        exp_q.delete();
      end else if (!was_active && start) begin
        if (len == 16'd0) begin
          m_done = 1'b1;
        end else begin
          build_exp(int'(offset), int'(len));
          m_active = 1'b1;
        end
      end
      prev_stall = pop.valid && !pop.ready;
      prev_clear = clear;
      prev_d     = pop.data;
      prev_s     = pop.strb;
    end
  end

  task automatic add_word(input logic [31:0] w, input logic [3:0] s);
    tx_w.push_back(w);
    tx_s.push_back(s);
  endtask

  task automatic gen_words(input int ln, input bit rstrb);
    tx_w.delete();
    tx_s.delete();
    for (int i = 0; i < ln; i++) add_word($urandom, rstrb ? 4'($urandom) : 4'hF);
  endtask

  task automatic start_xfer(input int off, input int ln, input int ps, input int qs);
    push_stall = ps;
    pop_stall  = qs;
    cap_q.delete();
    m_finished = 1'b0;
    for (int i = 0; i < tx_w.size(); i++) drv_q.push_back({tx_w[i], tx_s[i]});
    @(posedge clk);
    #1;
    offset = 2'(off);
    len    = 16'(ln);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int i;
    i = 0;
    while (!m_finished && i < bound) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (!m_finished) begin
      n_fail++;
      $display("FAIL %s_timeout: actual no done in %0d cycles, required done", name, bound);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first_beat();
    int i;
    i = 0;
    while (cap_q.size() < 1 && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("first_beat_seen", 32'(cap_q.size()), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; test_mode = 1'b0; start = 1'b0;
    offset = 2'd0; len = 16'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pop_valid", 32'(pop.valid), 32'd0);
    chk("rst_push_ready", 32'(push.ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // aligned transfer, no stalls
    tx_w.delete(); tx_s.delete();
    add_word(32'hA1A2A3A4, 4'hF); add_word(32'hB1B2B3B4, 4'hF); add_word(32'hC1C2C3C4, 4'hF);
    start_xfer(0, 3, 0, 0);
    wait_done("off0", 200);
    chk("off0_count", 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      chk("off0_b0", cap_q[0].d, 32'hA1A2A3A4);
      chk("off0_b2", cap_q[2].d, 32'hC1C2C3C4);
      chk("off0_s1", 32'(cap_q[1].s), 32'hF);
    end

    // offset 1, literal beats
    tx_w.delete(); tx_s.delete();
    add_word(32'h44332211, 4'hF); add_word(32'h88776655, 4'hF);
    start_xfer(1, 2, 0, 0);
    wait_done("off1", 200);
    chk("off1_count", 32'(cap_q.size()), 32'd3);
    if (cap_q.size() == 3) begin
      chk("off1_b0", cap_q[0].d, 32'h33221100);
      chk("off1_s0", 32'(cap_q[0].s), 32'hE);
      chk("off1_b1", cap_q[1].d, 32'h77665544);
      chk("off1_s1", 32'(cap_q[1].s), 32'hF);
      chk("off1_b2", cap_q[2].d, 32'h00000088);
      chk("off1_s2", 32'(cap_q[2].s), 32'h1);
    end

    // offset 3, random data, stalls on both sides
    gen_words(4, 1'b0);
    start_xfer(3, 4, 20, 20);
    wait_done("off3", 500);
    chk("off3_count", 32'(cap_q.size()), 32'd5);

    // zero-length start
    tx_w.delete(); tx_s.delete();
    start_xfer(2, 0, 0, 0);
    wait_done("len0", 50);
    chk("len0_count", 32'(cap_q.size()), 32'd0);

    // clear while draining the carry beat
    tx_w.delete(); tx_s.delete();
    add_word(32'h11223344, 4'hF);
    start_xfer(1, 1, 0, 0);
    wait_first_beat();
    force_low = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    #1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_pop_valid", 32'(pop.valid), 32'd0);
    force_low = 1'b0;

    // offset 2 after clear
    tx_w.delete(); tx_s.delete();
    add_word(32'hDEADBEEF, 4'hF);
    start_xfer(2, 1, 0, 0);
    wait_done("off2", 200);
    chk("off2_count", 32'(cap_q.size()), 32'd2);
    if (cap_q.size() == 2) begin
      chk("off2_b0", cap_q[0].d, 32'hBEEF0000);
      chk("off2_s0", 32'(cap_q[0].s), 32'hC);
      chk("off2_b1", cap_q[1].d, 32'h0000DEAD);
      chk("off2_s1", 32'(cap_q[1].s), 32'h3);
    end

    // start pulse with another offset while streaming is ignored
    gen_words(3, 1'b0);
    start_xfer(1, 3, 0, 0);
    wait_first_beat();
    @(posedge clk);
    #1;
    offset = 2'd3;
    len    = 16'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("restart", 200);
    chk("restart_count", 32'(cap_q.size()), 32'd4);
    if (cap_q.size() == 4) begin
      chk("restart_b0", cap_q[0].d, tx_w[0] << 8);
      chk("restart_b3", cap_q[3].d, tx_w[2] >> 24);
    end

    // random transfers
    for (int t = 0; t < 30; t++) begin
      int ln, off;
      ln  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(8, 1));
      off = int'($urandom_range(3));
      gen_words(ln, 1'b1);
      start_xfer(off, ln, int'($urandom_range(40)), int'($urandom_range(40)));
      wait_done("rand", 600);
      chk("rand_count", 32'(cap_q.size()), 32'(ln + ((ln != 0 && off != 0) ? 1 : 0)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
